muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small op-decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op_a_signed(op) && (op != OP_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle on unsigned magnitudes, sign fix-up applied on the final iteration.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  dz_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [2:0]        op_reg;
  logic              neg_reg;
  logic [W-1:0]      hi_reg, lo_reg, opnd_reg;
  logic [W-1:0]      res_reg;
  logic [TAG_WIDTH-1:0] tag_reg;
  logic              dz_reg;

  logic              accept, is_div, a_neg, b_neg, b_zero, ovf, shortcut, last_iter;
  logic [W-1:0]      a_mag, b_mag, shortcut_res, most_neg;

  always_comb begin
    most_neg     = {1'b1, {(W-1){1'b0}}};
    accept       = valid_i && (state_reg == IDLE) && !flush_i;
    is_div       = op_i[2];
    a_neg        = op_a_signed(op_i) && a_i[W-1];
    b_neg        = op_b_signed(op_i) && b_i[W-1];
    a_mag        = a_neg ? -a_i : a_i;
    b_mag        = b_neg ? -b_i : b_i;
    b_zero       = (b_i == '0);
    ovf          = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == most_neg) && (b_i == '1);
    shortcut     = is_div && (b_zero || ovf);
    // Divide-by-zero and signed overflow bypass the iteration entirely.
    if (b_zero) shortcut_res = op_i[1] ? a_i : '1;
    else        shortcut_res = op_i[1] ? '0 : a_i;
    last_iter    = (state_reg == CALC) && (count_reg == CW'(1));
  end

  // Shared W+1-bit adder: adds the multiplicand in mul mode, subtracts the
  // divisor from the shifted partial remainder in div mode.
  logic         sub, q_bit;
  logic [W:0]   add_a, add_b, add_sum;
  logic [W-1:0] hi_next, lo_next, calc_res;
  logic [2*W-1:0] prod, prod_fix;

  always_comb begin
    sub = op_reg[2];
    if (sub) begin
      add_a = {hi_reg, lo_reg[W-1]};
      add_b = {1'b0, opnd_reg};
    end else begin
      add_a = {1'b0, hi_reg};
      add_b = lo_reg[0] ? {1'b0, opnd_reg} : '0;
    end
    add_sum = add_a + (sub ? ~add_b : add_b) + {{W{1'b0}}, sub};
    q_bit   = ~add_sum[W];
    if (sub) begin
      hi_next = q_bit ? add_sum[W-1:0] : add_a[W-1:0];
      lo_next = {lo_reg[W-2:0], q_bit};
    end else begin
      {hi_next, lo_next} = {add_sum, lo_reg[W-1:1]};
    end
    prod     = {hi_next, lo_next};
    prod_fix = neg_reg ? -prod : prod;
    case (op_reg)
      OP_MUL:                    calc_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:           calc_res = neg_reg ? -lo_next : lo_next;
      default:                   calc_res = neg_reg ? -hi_next : hi_next;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = shortcut ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_reg <= '0;
      res_reg   <= '0;
      tag_reg   <= '0;
      dz_reg    <= 1'b0;
    end else if (accept) begin
      count_reg <= CW'(W);
      tag_reg   <= tag_i;
      dz_reg    <= shortcut && b_zero;
      if (shortcut) res_reg <= shortcut_res;
    end else if ((state_reg == CALC) && !flush_i) begin
      count_reg <= count_reg - CW'(1);
      if (last_iter) res_reg <= calc_res;
    end
  end

  // Remainder follows the dividend's sign; product/quotient follow sign XOR.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_reg   <= op_i;
      neg_reg  <= (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
      hi_reg   <= '0;
      lo_reg   <= is_div ? a_mag : b_mag;
      opnd_reg <= is_div ? b_mag : a_mag;
    end else if (state_reg == CALC) begin
      hi_reg   <= hi_next;
      lo_reg   <= lo_next;
    end
  end

  assign ready_o = (state_reg == IDLE);
  assign valid_o = (state_reg == DONE);
  assign res_o   = res_reg;
  assign tag_o   = tag_reg;
  assign dz_o    = dz_reg;

endmodule
